// File: rtl/pdm_pkg.sv
// Shared constants and helpers for the PDM modulator/demodulator family.
// Used by pdm, pdm_demod and saw so that widths and full scale agree.
package pdm_pkg;

  // Default sample width shared by modulator and demodulator
  localparam int PDM_NBITS_DEFAULT = 10;

  // CIC internal register width: enough bits for the gain R**ORDER plus one
  function automatic int cic_width(input int order, input int log2_dec);
    return order * log2_dec + 1;
  endfunction

  // Full-scale sample value for an nbits-wide unsigned sample
  function automatic int PDM_MAX(input int nbits);
    return (1 << nbits) - 1;
  endfunction

endpackage

// File: rtl/pdm_cic_comb.sv
// One registered CIC comb stage: y = x - x_delayed, evaluated only on adv.
// y_valid is adv delayed by one clock so stages can be chained.
module pdm_cic_comb #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  input  logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         y_valid
);

  logic [W-1:0] dly;

  // Differentiate against the previous decimated sample; wraparound is intended
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= adv;
      if (adv) begin
        dly <= x;
        y   <= x - dly;
      end
    end
  end

endmodule

// File: rtl/pdm_demod.sv
// PDM demodulator: ORDER-stage CIC decimator by R = 2**LOG2_DEC, scaled to an
// NBITS unsigned sample. Optional input synchronizers under PDM_DEMOD_SYNC_EN
// (adds 2 clk of latency to everything, measured from the ports).
module pdm_demod
  import pdm_pkg::*;
#(
  parameter int NBITS    = PDM_NBITS_DEFAULT,
  parameter int LOG2_DEC = 6,
  parameter int ORDER    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pdm_in,
  input  logic             pdm_valid,
  output logic [NBITS-1:0] sample_out,
  output logic             sample_valid
);

  localparam int W   = cic_width(ORDER, LOG2_DEC);
  localparam int SW  = $clog2(ORDER + 1);
  localparam int SHR = (W - 1 >= NBITS) ? (W - 1 - NBITS) : 0;
  localparam int SHL = (W - 1 >= NBITS) ? 0 : (NBITS - (W - 1));
  localparam logic [SW-1:0]    SETTLE_DONE = SW'(ORDER);
  localparam logic [NBITS-1:0] FULL_SCALE  = NBITS'(PDM_MAX(NBITS));

  logic bit_in;
  logic bit_vld;

`ifdef PDM_DEMOD_SYNC_EN
  logic [1:0] in_sync;
  logic [1:0] vld_sync;

  // Two-flop synchronizers for asynchronous external pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_sync  <= '0;
      vld_sync <= '0;
    end else begin
      in_sync  <= {in_sync[0], pdm_in};
      vld_sync <= {vld_sync[0], pdm_valid};
    end
  end

  assign bit_in  = in_sync[1];
  assign bit_vld = vld_sync[1];
`else
  assign bit_in  = pdm_in;
  assign bit_vld = pdm_valid;
`endif

  logic [LOG2_DEC-1:0]     dec_cnt;
  logic [ORDER-1:0][W-1:0] integ;
  logic                    dec_evt;
  logic                    dec_q;
  logic [W-1:0]            cap;
  logic                    cap_v;

  // The last accepted bit of each frame is the one that wraps dec_cnt
  assign dec_evt = bit_vld && (dec_cnt == '1);

  // Integrator cascade and frame counter, advancing only on accepted bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_cnt <= '0;
      integ   <= '0;
    end else if (bit_vld) begin
      dec_cnt  <= dec_cnt + LOG2_DEC'(1);
      integ[0] <= integ[0] + {{(W-1){1'b0}}, bit_in};
      for (int k = 1; k < ORDER; k++) begin
        integ[k] <= integ[k] + integ[k-1];
      end
    end
  end

  // Capture the last integrator one clock after the decimation event, so the
  // captured value already includes the frame's final bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_q <= 1'b0;
      cap   <= '0;
      cap_v <= 1'b0;
    end else begin
      dec_q <= dec_evt;
      cap_v <= dec_q;
      if (dec_q) begin
        cap <= integ[ORDER-1];
      end
    end
  end

  logic [W-1:0] comb_x [ORDER+1];
  logic         comb_v [ORDER+1];

  assign comb_x[0] = cap;
  assign comb_v[0] = cap_v;

  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    pdm_cic_comb #(
      .W(W)
    ) u_comb (
      .clk    (clk),
      .rst    (rst),
      .adv    (comb_v[k]),
      .x      (comb_x[k]),
      .y      (comb_x[k+1]),
      .y_valid(comb_v[k+1])
    );
  end

  logic [W-1:0]       comb_out;
  logic [W+NBITS-1:0] scale_wide;
  logic [NBITS-1:0]   scaled;

  assign comb_out = comb_x[ORDER];

  // Map comb output (0..R**ORDER) onto 0..2**NBITS-1; only exact full scale
  // sets the top bit, and that case saturates
  always_comb begin
    scale_wide = {{(NBITS+1){1'b0}}, comb_out[W-2:0]};
    scale_wide = (scale_wide << SHL) >> SHR;
    if (comb_out[W-1]) begin
      scaled = FULL_SCALE;
    end else begin
      scaled = scale_wide[NBITS-1:0];
    end
  end

  logic [SW-1:0] settle_cnt;

  // Output register; the first ORDER comb results carry start-up transients
  // and are swallowed while the settle counter fills
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt   <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (comb_v[ORDER]) begin
        if (settle_cnt == SETTLE_DONE) begin
          sample_out   <= scaled;
          sample_valid <= 1'b1;
        end else begin
          settle_cnt <= settle_cnt + SW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_demod.sv
// Bench for pdm_demod: table of stream scenarios checked against a closed-form
// CIC model (binomial-weighted bit sums, ORDER-th difference of decimated
// samples), plus a hand-written asynchronous mid-run reset sequence.
module tb_pdm_demod;

  localparam int NB   = 10;
  localparam int LD   = 6;
  localparam int ORD  = 2;
  localparam int R    = 1 << LD;
  localparam int W    = ORD * LD + 1;
  localparam int L    = ORD + 2;
  localparam longint MODW = 64'd1 << W;
`ifdef PDM_DEMOD_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pdm_in = 1'b0;
  logic          pdm_valid = 1'b0;
  logic [NB-1:0] sample_out;
  logic          sample_valid;

  pdm_demod #(.NBITS(NB), .LOG2_DEC(LD), .ORDER(ORD)) dut (
    .clk         (clk),
    .rst         (rst),
    .pdm_in      (pdm_in),
    .pdm_valid   (pdm_valid),
    .sample_out  (sample_out),
    .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int scn   = 0;
  int cur_e = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s: got %0d want %0d (scenario %0d edge %0d)", name, act, exp, scn, cur_e);
    end
  endtask

  task automatic check_tol(input string name, input int act, input int exp, input int tol);
    n_cmp++;
    if (act > exp + tol || act < exp - tol) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s: got %0d want %0d +/- %0d (scenario %0d edge %0d)", name, act, exp, tol, scn, cur_e);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; int val; } pend_t;
  bit     bq[$];
  longint s_hist[$];
  pend_t  pq[$];

  function automatic longint binom(input int n, input int k);
    longint r = 1;
    if (k < 0 || n < k) return 0;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // Last integrator after t accepted bits: each bit j weighted by C(t-1-j, ORD-1)
  function automatic longint cic_s(input int t);
    longint s = 0;
    for (int j = 0; j < t; j++)
      if (bq[j]) s += binom(t - 1 - j, ORD - 1);
    return s % MODW;
  endfunction

  function automatic int scale(input longint c);
    if (c >= (MODW >> 1)) return (1 << NB) - 1;
    if (W - 1 >= NB) return int'(c >> (W - 1 - NB));
    return int'(c << (NB - (W - 1)));
  endfunction

  task automatic model_clear();
    bq.delete();
    s_hist.delete();
    pq.delete();
  endtask

  task automatic model_accept(input bit b, input int e);
    longint c;
    int     n;
    pend_t  p;
    bq.push_back(b);
    if (bq.size() % R == 0) begin
      s_hist.push_back(cic_s(bq.size()));
      n = s_hist.size();
      c = 0;
      for (int m = 0; m <= ORD; m++)
        if (n - 1 - m >= 0)
          c += ((m % 2) ? -1 : 1) * binom(ORD, m) * s_hist[n - 1 - m];
      c = c % MODW;
      if (c < 0) c += MODW;
      if (n > ORD) begin
        p.due = e + L + SYNC;
        p.val = scale(c);
        pq.push_back(p);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  // mode: 0 const0, 1 const1, 2 alternating 1,0, 3 first-order PDM of arg, 4 random density arg%
  // vmode: 0 always valid, 1 valid on odd edges, 2 random valid vpct%
  typedef struct {
    int mode; int arg; int vmode; int vpct; int ncyc;
    int exp_val; int tol; int exp_first; int period;
  } vec_t;

  task automatic do_reset();
    rst = 1'b1; pdm_valid = 1'b0; pdm_in = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_out", 32'(sample_out), 32'd0);
      check("rst_valid", 32'(sample_valid), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts and ends at a negedge with rst released
  task automatic run_scn(input vec_t v);
    int  mod_acc = 0;
    int  first = -1;
    int  last = -1;
    int  exp_out = 0;
    bit  vld, b, exp_v;
    model_clear();
    for (int e = 1; e <= v.ncyc; e++) begin
      cur_e = e;
      case (v.vmode)
        0: vld = 1'b1;
        1: vld = (e % 2 == 1);
        default: vld = ($urandom_range(0, 99) < v.vpct);
      endcase
      case (v.mode)
        0: b = 1'b0;
        1: b = 1'b1;
        2: b = (e % 2 == 1);
        3: begin
          b = 1'b0;
          if (vld) begin
            mod_acc += v.arg;
            if (mod_acc >= (1 << NB)) begin b = 1'b1; mod_acc -= (1 << NB); end
          end
        end
        default: b = ($urandom_range(0, 99) < v.arg);
      endcase
      pdm_valid = vld;
      pdm_in    = b;
      @(posedge clk); #1;
      if (vld) model_accept(b, e);
      exp_v = (pq.size() > 0 && pq[0].due == e);
      if (exp_v) begin
        exp_out = pq[0].val;
        void'(pq.pop_front());
      end
      check("valid", 32'(sample_valid), 32'(exp_v));
      check("out", 32'(sample_out), 32'(exp_out));
      if (sample_valid === 1'b1) begin
        if (first < 0) first = e;
        else if (v.period > 0) check("period", 32'(e - last), 32'(v.period));
        if (v.exp_val >= 0) check_tol("level", int'(sample_out), v.exp_val, v.tol);
        last = e;
      end
      @(negedge clk);
    end
    if (v.exp_first > 0) check("first_pulse", 32'(first), 32'(v.exp_first + SYNC));
  endtask

  vec_t tbl[8];
  vec_t hv;

  initial begin
    //          mode arg vmode vpct ncyc  val   tol first period
    tbl[0] = '{0,   0,   0,   0,  500,    0,  0, 196,  64};
    tbl[1] = '{1,   0,   0,   0,  500, 1023,  0, 196,  64};
    tbl[2] = '{2,   0,   0,   0,  500,  512,  0, 196,  64};
    tbl[3] = '{1,   0,   1,   0,  900, 1023,  0, 387, 128};
    tbl[4] = '{3, 256,   0,   0,  600,  256,  2, 196,  64};
    tbl[5] = '{3, 768,   0,   0,  600,  768,  2, 196,  64};
    tbl[6] = '{4,  30,   2,  70, 1500,   -1,  0,   0,   0};
    tbl[7] = '{4,  85,   0,   0,  800,   -1,  0,   0,   0};

    for (int i = 0; i < 8; i++) begin
      scn = i;
      do_reset();
      run_scn(tbl[i]);
    end

    // Asynchronous reset in the middle of a run, with a non-zero held sample
    scn = 8;
    do_reset();
    hv = '{1, 0, 0, 0, 300, 1023, 0, 196, 64};
    run_scn(hv);
    check("pre_rst_out", 32'(sample_out), 32'd1023);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", 32'(sample_out), 32'd0);
    check("async_rst_valid", 32'(sample_valid), 32'd0);
    pdm_valid = 1'b1; pdm_in = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("hold_rst_out", 32'(sample_out), 32'd0);
      check("hold_rst_valid", 32'(sample_valid), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    scn = 9;
    hv = '{1, 0, 0, 0, 500, 1023, 0, 196, 64};
    run_scn(hv);

    // Partial frame of 100 bits, reset, then an alternating stream
    scn = 10;
    do_reset();
    hv = '{4, 50, 0, 0, 100, -1, 0, 0, 0};
    run_scn(hv);
    #3 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("rst100_out", 32'(sample_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    scn = 11;
    hv = '{2, 0, 0, 0, 400, 512, 0, 196, 64};
    run_scn(hv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
